// File: rtl/booth_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential Booth multiplier.
// The controller takes the slave side; the operand source and product sink take master.
interface booth_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequencer for an 8x8 signed radix-2 Booth multiplier: accepts an operand pair,
// runs STEPS_PER_CLK chained substeps per cycle for 8 substeps, then offers the 16-bit product.
module booth_seq_ctrl #(
    parameter int STEPS_PER_CLK = 1
) (
    input  logic             clk,
    input  logic             rst,
    booth_seq_ctrl_if.slave  bus
);

    if (STEPS_PER_CLK != 1 && STEPS_PER_CLK != 2 &&
        STEPS_PER_CLK != 4 && STEPS_PER_CLK != 8) begin : g_bad_steps
        $error("booth_seq_ctrl: STEPS_PER_CLK must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  acc_q;
    logic [7:0]  q_q;
    logic        qm1_q;
    logic [7:0]  m_q;
    logic [3:0]  cnt_q;
    logic        bypass_q;
    logic [15:0] product_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic        busy_q;

    logic [7:0]  acc_d;
    logic [7:0]  q_d;
    logic        qm1_d;
    logic [3:0]  cnt_d;

    // Combinational chain of Booth substeps: add/subtract M on {Q0,q-1}, then
    // arithmetic shift right of {acc, Q, q-1}.
    for (genvar gi = 0; gi < STEPS_PER_CLK; gi++) begin : g_step
        logic [7:0] acc_in;
        logic [7:0] q_in;
        logic       qm1_in;
        logic [7:0] sum;
        logic [7:0] acc_o;
        logic [7:0] q_o;
        logic       qm1_o;

        if (gi == 0) begin : g_first
            assign acc_in = acc_q;
            assign q_in   = q_q;
            assign qm1_in = qm1_q;
        end else begin : g_chain
            assign acc_in = g_step[gi-1].acc_o;
            assign q_in   = g_step[gi-1].q_o;
            assign qm1_in = g_step[gi-1].qm1_o;
        end

        always_comb begin
            sum = acc_in;
            case ({q_in[0], qm1_in})
                2'b01:   sum = acc_in + m_q;
                2'b10:   sum = acc_in - m_q;
                default: sum = acc_in;
            endcase
        end

        assign acc_o = {sum[7], sum[7:1]};
        assign q_o   = {sum[0], q_in[7:1]};
        assign qm1_o = q_in[0];
    end

    assign acc_d = g_step[STEPS_PER_CLK-1].acc_o;
    assign q_d   = g_step[STEPS_PER_CLK-1].q_o;
    assign qm1_d = g_step[STEPS_PER_CLK-1].qm1_o;
    assign cnt_d = cnt_q + 4'(STEPS_PER_CLK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            m_q         <= '0;
            cnt_q       <= '0;
            bypass_q    <= 1'b0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // -M for M=-128 does not fit in 8 bits, so -128 is steered
                        // to the multiplier side; -128 x -128 is patched at the end.
                        if (bus.multiplicand == 8'h80 && bus.multiplier != 8'h80) begin
                            m_q      <= bus.multiplier;
                            q_q      <= bus.multiplicand;
                            bypass_q <= 1'b0;
                        end else begin
                            m_q      <= bus.multiplicand;
                            q_q      <= bus.multiplier;
                            bypass_q <= (bus.multiplicand == 8'h80);
                        end
                        acc_q      <= '0;
                        qm1_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == 4'd8) begin
                        product_q   <= bypass_q ? 16'h4000 : {acc_d, q_d};
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Drives identical operand traffic into three controllers (1, 2 and 4 substeps per clock)
// and compares each against plain signed multiplication.
module tb_booth_seq_ctrl;

    localparam int STEPS [3] = '{1, 2, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a_r;
    logic [7:0] b_r;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    booth_seq_ctrl_if bif1 ();
    booth_seq_ctrl_if bif2 ();
    booth_seq_ctrl_if bif4 ();

    assign bif1.in_valid = in_valid;  assign bif1.multiplicand = a_r;
    assign bif1.multiplier = b_r;     assign bif1.out_ready = out_ready;
    assign bif2.in_valid = in_valid;  assign bif2.multiplicand = a_r;
    assign bif2.multiplier = b_r;     assign bif2.out_ready = out_ready;
    assign bif4.in_valid = in_valid;  assign bif4.multiplicand = a_r;
    assign bif4.multiplier = b_r;     assign bif4.out_ready = out_ready;

    booth_seq_ctrl #(.STEPS_PER_CLK(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1.slave));
    booth_seq_ctrl #(.STEPS_PER_CLK(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bif2.slave));
    booth_seq_ctrl #(.STEPS_PER_CLK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bif4.slave));

    wire [2:0] ov = {bif4.out_valid, bif2.out_valid, bif1.out_valid};
    wire [2:0] ir = {bif4.in_ready,  bif2.in_ready,  bif1.in_ready};
    wire [2:0] by = {bif4.busy,      bif2.busy,      bif1.busy};
    logic [15:0] pr [3];
    assign pr[0] = bif1.product;
    assign pr[1] = bif2.product;
    assign pr[2] = bif4.product;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[15:0];
    endfunction

    task automatic do_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] exp;
        bit          seen [3];
        int          lat [3];
        exp = ref_mul(a, b);
        for (int d = 0; d < 3; d++) begin
            seen[d] = 1'b0;
            lat[d]  = 0;
        end
        @(negedge clk);
        chk("in_ready_idle", 32'(ir), 32'h7);
        in_valid = 1'b1;
        a_r = a;
        b_r = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_run", 32'(by), 32'h7);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (!seen[d] && ov[d]) begin
                    seen[d] = 1'b1;
                    lat[d]  = cyc;
                    chk($sformatf("latency_s%0d", STEPS[d]), 32'(cyc), 32'(8 / STEPS[d]));
                    chk($sformatf("product_s%0d", STEPS[d]), 32'(pr[d]), 32'(exp));
                end else if (seen[d] && cyc == lat[d] + 1) begin
                    chk($sformatf("release_s%0d", STEPS[d]), {30'd0, ov[d], ir[d]}, 32'h1);
                end
            end
        end
        for (int d = 0; d < 3; d++)
            if (!seen[d]) chk($sformatf("timeout_s%0d", STEPS[d]), 32'd0, 32'd1);
        $display("mul %0d x %0d -> expected %04h, products %04h %04h %04h",
                 $signed(a), $signed(b), exp, pr[0], pr[1], pr[2]);
    endtask

    initial begin
        logic [15:0] bp_exp;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_r       = '0;
        b_r       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(ov), 32'h0);
        chk("reset_busy", 32'(by), 32'h0);
        chk("reset_in_ready", 32'(ir), 32'h7);
        chk("reset_product", {pr[0], pr[1]}, 32'h0);

        do_mul(8'd3, 8'd5);
        do_mul(8'hF9, 8'd6);
        do_mul(8'd0, 8'hFF);
        do_mul(8'd127, 8'd127);
        do_mul(8'h80, 8'd5);
        do_mul(8'd5, 8'h80);
        do_mul(8'h80, 8'h80);

        // Backpressure: product parked in DONE while in_valid pulses are offered.
        bp_exp    = ref_mul(8'd19, 8'hF9);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        a_r = 8'd19;
        b_r = 8'hF9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(ov), 32'h7);
            chk("bp_in_ready", 32'(ir), 32'h0);
            for (int d = 0; d < 3; d++)
                chk($sformatf("bp_product_s%0d", STEPS[d]), 32'(pr[d]), 32'(bp_exp));
            in_valid = 1'b1;
            a_r = 8'($urandom);
            b_r = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(ov), 32'h0);
        chk("bp_release_ready", 32'(ir), 32'h7);
        chk("bp_product_kept", 32'(pr[0]), 32'(bp_exp));
        $display("backpressure 19 x -7 -> expected %04h, held %04h", bp_exp, pr[0]);

        // Reset in the middle of a run.
        @(negedge clk);
        in_valid = 1'b1;
        a_r = 8'd100;
        b_r = 8'd77;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(ov), 32'h0);
        chk("midrst_busy", 32'(by), 32'h0);
        chk("midrst_product", {pr[0], pr[2]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(ir), 32'h7);
        $display("reset during run -> products %04h %04h %04h", pr[0], pr[1], pr[2]);
        do_mul(8'hFE, 8'hFD);

        for (int i = 0; i < 20; i++)
            do_mul(8'($urandom), 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
